// File: rtl/axi_fifo_flop.sv
// Single-register AXI-Stream stage: holds one beat, accepts a new one when empty
// or when the held beat leaves in the same cycle.
module axi_fifo_flop #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tvalid,
  input  logic             o_tready
);

  logic [WIDTH-1:0] data_p1;
  logic             vld_p1;

  assign i_tready = ~vld_p1 | o_tready;

  // Stage p1: output register
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (i_tready) begin
      vld_p1 <= i_tvalid;
      if (i_tvalid) data_p1 <= i_tdata;
    end
  end

  assign o_tdata  = data_p1;
  assign o_tvalid = vld_p1;

endmodule

// File: rtl/invert_merge_check.sv
// Joins a pass-through stream and its bitwise-inverted twin, checks B == ~A beat by
// beat with matching framing, forwards A and keeps saturating error/packet counters.
module invert_merge_check #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] a_tdata,
  input  logic             a_tlast,
  input  logic             a_tvalid,
  output logic             a_tready,
  input  logic [WIDTH-1:0] b_tdata,
  input  logic             b_tlast,
  input  logic             b_tvalid,
  output logic             b_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             o_terr,
  output logic [CNT_W-1:0] data_err_cnt,
  output logic [CNT_W-1:0] frame_err_cnt,
  output logic [CNT_W-1:0] pkt_cnt
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_DRAIN_A = 2'd1;
  localparam logic [1:0] ST_DRAIN_B = 2'd2;

  logic [1:0]       state;
  logic             out_can_accept;
  logic             join_vld_p0;
  logic             mismatch_p0;
  logic             last_p0;
  logic [WIDTH+1:0] join_data_p0;
  logic [WIDTH+1:0] out_data_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Stage p0: join A and B; in RUN a beat moves only when both sides and the output are ready
  always_comb begin
    a_tready    = 1'b0;
    b_tready    = 1'b0;
    join_vld_p0 = 1'b0;
    case (state)
      ST_RUN: begin
        join_vld_p0 = a_tvalid & b_tvalid & out_can_accept;
        a_tready    = join_vld_p0;
        b_tready    = join_vld_p0;
      end
      ST_DRAIN_A: a_tready = 1'b1;
      ST_DRAIN_B: b_tready = 1'b1;
      default: ;
    endcase
  end

  assign mismatch_p0  = (a_tdata != ~b_tdata);
  assign last_p0      = a_tlast | b_tlast;
  assign join_data_p0 = {mismatch_p0, last_p0, a_tdata};

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state         <= ST_RUN;
      data_err_cnt  <= '0;
      frame_err_cnt <= '0;
      pkt_cnt       <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (join_vld_p0) begin
            if (mismatch_p0) data_err_cnt <= sat_inc(data_err_cnt);
            if (last_p0)     pkt_cnt      <= sat_inc(pkt_cnt);
            // The shorter side closed the packet; discard the longer side's remainder
            if (a_tlast != b_tlast) begin
              frame_err_cnt <= sat_inc(frame_err_cnt);
              state         <= a_tlast ? ST_DRAIN_B : ST_DRAIN_A;
            end
          end
        end
        ST_DRAIN_A: if (a_tvalid && a_tlast) state <= ST_RUN;
        ST_DRAIN_B: if (b_tvalid && b_tlast) state <= ST_RUN;
        default: state <= ST_RUN;
      endcase
    end
  end

  // Stage p1: single output register
  axi_fifo_flop #(
    .WIDTH(WIDTH + 2)
  ) u_out (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .i_tdata  (join_data_p0),
    .i_tvalid (join_vld_p0),
    .i_tready (out_can_accept),
    .o_tdata  (out_data_p1),
    .o_tvalid (o_tvalid),
    .o_tready (o_tready)
  );

  assign {o_terr, o_tlast, o_tdata} = out_data_p1;

endmodule

// File: tb/tb_invert_merge_check.sv
// Scoreboard bench for invert_merge_check: packet-level model, randomized drivers,
// and a second instance with 2-bit counters to observe saturation.
module tb_invert_merge_check;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;
  localparam int SAT_W = 2;

  typedef struct packed {logic [31:0] d; logic l;} beat_t;
  typedef struct packed {logic [31:0] d; logic l; logic e;} obeat_t;

  logic clk = 1'b0;
  logic reset, clear;
  logic [WIDTH-1:0] a_tdata, b_tdata;
  logic a_tlast, a_tvalid, b_tlast, b_tvalid, o_tready;
  logic a_tready, b_tready, o_tlast, o_tvalid, o_terr;
  logic [WIDTH-1:0] o_tdata;
  logic [CNT_W-1:0] data_err_cnt, frame_err_cnt, pkt_cnt;
  logic s_a_tready, s_b_tready, s_o_tlast, s_o_tvalid, s_o_terr;
  logic [WIDTH-1:0] s_o_tdata;
  logic [SAT_W-1:0] s_data_err_cnt, s_frame_err_cnt, s_pkt_cnt;

  always #5 clk = ~clk;

  invert_merge_check #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset(reset), .clear(clear),
    .a_tdata(a_tdata), .a_tlast(a_tlast), .a_tvalid(a_tvalid), .a_tready(a_tready),
    .b_tdata(b_tdata), .b_tlast(b_tlast), .b_tvalid(b_tvalid), .b_tready(b_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .o_terr(o_terr), .data_err_cnt(data_err_cnt), .frame_err_cnt(frame_err_cnt),
    .pkt_cnt(pkt_cnt)
  );

  invert_merge_check #(.WIDTH(WIDTH), .CNT_W(SAT_W)) u_sat (
    .clk(clk), .reset(reset), .clear(clear),
    .a_tdata(a_tdata), .a_tlast(a_tlast), .a_tvalid(a_tvalid), .a_tready(s_a_tready),
    .b_tdata(b_tdata), .b_tlast(b_tlast), .b_tvalid(b_tvalid), .b_tready(s_b_tready),
    .o_tdata(s_o_tdata), .o_tlast(s_o_tlast), .o_tvalid(s_o_tvalid), .o_tready(o_tready),
    .o_terr(s_o_terr), .data_err_cnt(s_data_err_cnt), .frame_err_cnt(s_frame_err_cnt),
    .pkt_cnt(s_pkt_cnt)
  );

  beat_t  aq[$];
  beat_t  bq[$];
  obeat_t expq[$];
  logic [31:0] pa[$];
  logic [31:0] pb[$];
  int n_vec = 0, n_fail = 0, n_out = 0;
  int m_data = 0, m_frame = 0, m_pkt = 0;
  int gap_pct = 0, rdy_mode = 0;

  function automatic int satv(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_data_err"},  64'(data_err_cnt),    64'(satv(m_data, CNT_W)));
    check({tag, "_frame_err"}, 64'(frame_err_cnt),   64'(satv(m_frame, CNT_W)));
    check({tag, "_pkt"},       64'(pkt_cnt),         64'(satv(m_pkt, CNT_W)));
    check({tag, "_sat_data"},  64'(s_data_err_cnt),  64'(satv(m_data, SAT_W)));
    check({tag, "_sat_frame"}, 64'(s_frame_err_cnt), 64'(satv(m_frame, SAT_W)));
    check({tag, "_sat_pkt"},   64'(s_pkt_cnt),       64'(satv(m_pkt, SAT_W)));
  endtask

  task automatic fill_pkt(input int la, input int lb, input logic [31:0] base);
    pa.delete();
    pb.delete();
    for (int i = 0; i < la; i++) pa.push_back(base + 32'(i));
    for (int i = 0; i < lb; i++) pb.push_back(~(base + 32'(i)));
  endtask

  // Packet-level model: the shorter packet sets the output length, its last beat carries tlast
  task automatic send_pair(input int bdelay);
    int n;
    beat_t bt;
    obeat_t ob;
    n = (pa.size() < pb.size()) ? pa.size() : pb.size();
    for (int i = 0; i < n; i++) begin
      ob.d = pa[i];
      ob.l = (i == n - 1);
      ob.e = (pa[i] != ~pb[i]);
      expq.push_back(ob);
      if (ob.e) m_data++;
    end
    m_pkt++;
    if (pa.size() != pb.size()) m_frame++;
    for (int i = 0; i < pa.size(); i++) begin
      bt.d = pa[i]; bt.l = (i == pa.size() - 1); aq.push_back(bt);
    end
    if (bdelay > 0) begin
      repeat (bdelay) @(posedge clk);
      #2;
    end
    for (int i = 0; i < pb.size(); i++) begin
      bt.d = pb[i]; bt.l = (i == pb.size() - 1); bq.push_back(bt);
    end
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (aq.size() == 0 && bq.size() == 0 && expq.size() == 0 && !o_tvalid && !s_o_tvalid)
        done = 1;
    end
    if (!done) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s_timeout: aq=%0d bq=%0d exp=%0d left, required 0", tag,
               aq.size(), bq.size(), expq.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // A driver
  initial begin
    bit took;
    a_tvalid = 0; a_tdata = '0; a_tlast = 0;
    forever begin
      @(negedge clk);
      took = a_tvalid && a_tready;
      @(posedge clk);
      if (took && aq.size() > 0) aq.delete(0);
      #1;
      if (a_tvalid && !took && aq.size() > 0) begin
        a_tvalid = 1;
      end else if (aq.size() > 0 && $urandom_range(99) >= gap_pct) begin
        a_tvalid = 1; a_tdata = aq[0].d; a_tlast = aq[0].l;
      end else begin
        a_tvalid = 0; a_tdata = $urandom; a_tlast = 0;
      end
    end
  end

  // B driver
  initial begin
    bit took;
    b_tvalid = 0; b_tdata = '0; b_tlast = 0;
    forever begin
      @(negedge clk);
      took = b_tvalid && b_tready;
      @(posedge clk);
      if (took && bq.size() > 0) bq.delete(0);
      #1;
      if (b_tvalid && !took && bq.size() > 0) begin
        b_tvalid = 1;
      end else if (bq.size() > 0 && $urandom_range(99) >= gap_pct) begin
        b_tvalid = 1; b_tdata = bq[0].d; b_tlast = bq[0].l;
      end else begin
        b_tvalid = 0; b_tdata = $urandom; b_tlast = 0;
      end
    end
  end

  // Output ready: 0 = always, 1 = 1,0,0,1 pattern, 2 = random
  initial begin
    int ph;
    ph = 0;
    o_tready = 1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: begin o_tready = (ph == 0 || ph == 3); ph = (ph + 1) % 4; end
        2: o_tready = 1'($urandom_range(1));
        default: o_tready = 1;
      endcase
    end
  end

  // Monitor
  initial begin
    bit stall_prev;
    logic [34:0] held;
    obeat_t e;
    stall_prev = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!reset && !clear) begin
        if (stall_prev) check("hold_stable", 64'({o_tvalid, o_terr, o_tlast, o_tdata}), 64'(held));
        if (o_tvalid && o_tready) begin
          if (expq.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_beat: got 0x%0h, expected no beat", o_tdata);
          end else begin
            e = expq.pop_front();
            n_out++;
            check("beat", 64'({o_terr, o_tlast, o_tdata}), 64'({e.e, e.l, e.d}));
            check("sat_beat", 64'({s_o_tvalid, s_o_terr, s_o_tlast, s_o_tdata}),
                  64'({1'b1, e.e, e.l, e.d}));
          end
        end
        stall_prev = o_tvalid && !o_tready;
        held = {o_tvalid, o_terr, o_tlast, o_tdata};
      end else begin
        stall_prev = 0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int la, lb;
    reset = 1; clear = 0;
    repeat (3) @(posedge clk);
    #2 reset = 0;
    @(negedge clk);
    check("rst_out", 64'({o_tvalid, o_tlast, o_terr, o_tdata}), 64'(0));
    check("rst_ready", 64'({a_tready, b_tready, s_a_tready, s_b_tready}), 64'(0));
    check_cnts("rst");

    @(posedge clk); #2;
    n_out = 0;
    fill_pkt(8, 8, 32'h0);
    send_pair(1);
    wait_idle("matched");
    check("matched_beats", 64'(n_out), 64'(8));
    check_cnts("matched");

    @(posedge clk); #2;
    fill_pkt(8, 8, 32'h0);
    pb[3] = 32'h12345678;
    send_pair(0);
    wait_idle("corrupt");
    check_cnts("corrupt");

    @(posedge clk); #2;
    n_out = 0;
    fill_pkt(4, 6, 32'h100); send_pair(0);
    fill_pkt(2, 2, 32'h200); send_pair(0);
    wait_idle("early_a");
    check("early_a_beats", 64'(n_out), 64'(6));
    check_cnts("early_a");

    @(posedge clk); #2;
    fill_pkt(6, 4, 32'h300); send_pair(0);
    fill_pkt(2, 2, 32'h380); send_pair(0);
    wait_idle("early_b");
    check_cnts("early_b");

    @(posedge clk); #2;
    rdy_mode = 1;
    n_out = 0;
    fill_pkt(16, 16, 32'h400); send_pair(0);
    wait_idle("bp");
    check("bp_beats", 64'(n_out), 64'(16));
    check_cnts("bp");
    rdy_mode = 0;

    // Clear while the B side is still being drained
    @(posedge clk); #2;
    fill_pkt(2, 12, 32'h500); send_pair(0);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (aq.size() == 0 && expq.size() == 0 && !o_tvalid && bq.size() >= 3 && bq.size() <= 8)
        found = 1;
    end
    check("drain_b_reached", 64'(found), 64'(1));
    check("drain_b_ready", 64'({a_tready, b_tready}), 64'(2'b01));
    @(posedge clk); #2;
    clear = 1;
    bq.delete();
    expq.delete();
    m_data = 0; m_frame = 0; m_pkt = 0;
    @(posedge clk); #2;
    clear = 0;
    @(negedge clk);
    check("clear_out", 64'({o_tvalid, s_o_tvalid}), 64'(0));
    check_cnts("clear");
    @(posedge clk); #2;
    fill_pkt(3, 3, 32'h600); send_pair(0);
    wait_idle("post_clear");
    check_cnts("post_clear");

    @(posedge clk); #2;
    fill_pkt(5, 5, 32'h700);
    for (int i = 0; i < 5; i++) pb[i] = pa[i];
    send_pair(0);
    wait_idle("sat");
    check("sat_data_err", 64'(s_data_err_cnt), 64'(3));
    check_cnts("sat");

    gap_pct = 30;
    rdy_mode = 2;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #2;
      la = $urandom_range(1, 8);
      lb = ($urandom_range(99) < 70) ? la : $urandom_range(1, 8);
      fill_pkt(la, lb, $urandom);
      for (int i = 0; i < lb; i++) if ($urandom_range(99) < 20) pb[i] = $urandom;
      send_pair($urandom_range(0, 2));
    end
    wait_idle("random");
    check_cnts("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/invert_merge_check.md
Name: invert_merge_check

Overview:
- Receiving end of the pass-through/invert split.
- Joins the pass-through stream (A) and the inverted stream (B) beat by beat and checks that B equals the bitwise inverse of A, with matching packet boundaries.
- Forwards A's data on one output AXI-Stream and counts data and framing errors.
- Sits in the invert test block datapath, ahead of the noc_shell output.
- Tolerates any difference in latency between the A and B paths.

Parameters:
- WIDTH, 32, tdata width of A, B and the output.
- CNT_W, 16, width of each error and packet counter. Counters saturate at 2^CNT_W-1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- clear  in  1  synchronous soft clear: same effect as reset
- a_tdata  in  WIDTH  pass-through data
- a_tlast  in  1  pass-through end of packet
- a_tvalid  in  1  pass-through valid
- a_tready  out  1  pass-through ready
- b_tdata  in  WIDTH  inverted data
- b_tlast  in  1  inverted end of packet
- b_tvalid  in  1  inverted valid
- b_tready  out  1  inverted ready
- o_tdata  out  WIDTH  merged data (A's value)
- o_tlast  out  1  merged end of packet
- o_tvalid  out  1  merged valid
- o_tready  in  1  merged ready
- o_terr  out  1  per-beat flag: this beat had a data mismatch
- data_err_cnt  out  CNT_W  beats where a_tdata != ~b_tdata
- frame_err_cnt  out  CNT_W  tlast disagreements
- pkt_cnt  out  CNT_W  packets emitted on the output

Behaviour:
- Reset or clear: FSM goes to RUN, the output register empties, and all counters go to 0.
  - o_tvalid=0, o_tdata=0, o_tlast=0, o_terr=0.
  - a_tready and b_tready follow the RUN rule below (combinational), so both are 1 when A and B are both valid.
- Output stage is a single register stage, which can accept a new beat when it is empty or o_tready=1.
  - Latency from input join to o_tvalid is 1 cycle.
  - Full throughput is one beat per cycle.
- FSM states: RUN, DRAIN_A, DRAIN_B.
- RUN:
  - a_tready = b_tready = a_tvalid & b_tvalid & out_can_accept. A beat joins only when both inputs are valid; there is never a one-sided transfer in RUN.
  - On a join, the output register loads o_tdata=a_tdata, o_tlast=a_tlast|b_tlast, and o_terr=(a_tdata != ~b_tdata).
  - data_err_cnt increments when o_terr is set.
  - pkt_cnt increments on a joined beat whose output tlast is 1.
  - a_tlast=1 with b_tlast=0: frame_err_cnt increments and the FSM goes to DRAIN_B.
  - b_tlast=1 with a_tlast=0: frame_err_cnt increments and the FSM goes to DRAIN_A.
- DRAIN_B:
  - b_tready=1 and a_tready=0. B beats are discarded, with no output and no data compare.
  - On an accepted B beat with b_tlast=1, the FSM returns to RUN.
- DRAIN_A: mirror image of DRAIN_B, with A beats discarded until the A beat with a_tlast=1.
- Counters:
  - Saturate and never wrap.
  - If two counters have events in the same cycle, each updates independently.
- Output holds stable while o_tvalid=1 and o_tready=0. Inputs stall (ready=0 in RUN) until the output register frees.
- Clear asserted mid-packet or mid-drain: the FSM is forced to RUN, any buffered output beat is dropped, and all partial-packet state is lost. Clear has priority over all other events in the same cycle.
- Input tdata is don't-care when its tvalid=0. Counters and FSM change only on accepted handshakes.

Decomposition:
- No shared package.
  - State encodings are localparams (2-bit).
  - Counter width comes from CNT_W.
- Output stage: instantiate axi_fifo_flop with WIDTH+2 bits, packed as {o_terr, o_tlast, o_tdata}.
  - Its clear is tied to clear.
  - Its ready drives out_can_accept.
- The FSM, join logic and counters live in the top module. A natural RTL size is about 150 lines.

Test Plan:
- Matched streams:
  - Stimulus: A = 0x00000000..0x00000007 with tlast on beat 7; B = ~A with B delayed by 1 cycle relative to A; o_tready=1.
  - Response: 8 output beats equal to A; o_tlast on beat 7 only; o_terr=0; pkt_cnt=1; data_err_cnt=0; frame_err_cnt=0.
- Corrupt beat:
  - Stimulus: B beat 3 = 0x12345678 instead of ~0x00000003.
  - Response: output beat 3 has o_terr=1; data_err_cnt=1; all other beats are unaffected.
- Early A tlast:
  - Stimulus: A packet is 4 beats; B packet is 6 beats; then both send a clean 2-beat packet.
  - Response: 4 output beats, the last with tlast; B beats 4-5 are discarded; frame_err_cnt=1; the following 2-beat packet passes clean; pkt_cnt=2.
- Early B tlast:
  - Stimulus: mirror of the previous case, with B's packet shorter than A's.
  - Response: DRAIN_A discards A's trailing beats; frame_err_cnt=1.
- Backpressure:
  - Stimulus: o_tready toggles 1,0,0,1 repeatedly during a 16-beat packet.
  - Response: no beat is lost or duplicated, o_tdata is held stable while stalled, and the output sequence is intact.
- Clear mid-drain and saturation:
  - Clear mid-drain stimulus: assert clear while in DRAIN_B.
  - Clear mid-drain response: next cycle all counters are 0, o_tvalid=0, the FSM is in RUN, and the next matched packet is accepted normally.
  - Saturation stimulus: with CNT_W=2, send 5 corrupt beats.
  - Saturation response: data_err_cnt stays at 3.
